// File: rtl/pipe_elastic_stage_pkg.sv
// pipe_elastic_stage_pkg: stage payload structs, their widths, hazard control and pointer sizing
package pipe_elastic_stage_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } data_fetch_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu_op;
    } data_decode_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
        logic        mem_rd;
        logic        mem_wr;
    } data_execute_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        reg_wr;
    } data_memory_t;

    localparam int FETCH_W   = $bits(data_fetch_t);
    localparam int DECODE_W  = $bits(data_decode_t);
    localparam int EXECUTE_W = $bits(data_execute_t);
    localparam int MEMORY_W  = $bits(data_memory_t);

    typedef struct packed {
        logic flush;
        logic stall;
    } stage_ctl_t;

    // a single-entry buffer still needs a 1-bit pointer
    function automatic int ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_wrap_ptr.sv
// pipe_wrap_ptr: modulo-DEPTH pointer with increment and synchronous clear
module pipe_wrap_ptr
    import pipe_elastic_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       inc,
    output logic [ptr_w(DEPTH)-1:0]    ptr
);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk)
        if (!reset || clear) ptr <= '0;
        else if (inc) ptr <= ptr == LAST ? '0 : ptr + PW'(1);

endmodule

// File: rtl/pipe_elastic_stage.sv
// pipe_elastic_stage: DEPTH-entry in-order elastic buffer with valid/ready, flush and optional bypass
module pipe_elastic_stage
    import pipe_elastic_stage_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 2,
    parameter bit BYPASS = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             empty, pass, push, pop, wr, rd;

    // pass: empty bypass buffer presents the input directly; a consumed pass-through never touches storage
    always_comb begin
        empty     = count == '0;
        pass      = BYPASS && empty;
        in_ready  = count != FULL;
        out_valid = pass ? in_valid && !flush : !empty;
        out_data  = pass ? in_data : empty ? '0 : mem[rd_ptr];
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
        wr        = push && !(pass && pop);
        rd        = pop && !pass;
    end

    always_ff @(posedge clk)
        if (!reset || flush) count <= '0;
        else if (wr && !rd) count <= count + CW'(1);
        else if (rd && !wr) count <= count - CW'(1);

    always_ff @(posedge clk)
        if (!reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (wr) mem[wr_ptr] <= in_data;

    pipe_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (wr),
        .ptr   (wr_ptr)
    );

    pipe_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (rd),
        .ptr   (rd_ptr)
    );

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// tb_pipe_elastic_stage: scoreboard bench over DEPTH=2/BYPASS=0, DEPTH=3/BYPASS=0 and DEPTH=2/BYPASS=1
module tb_pipe_elastic_stage;

    logic        clk = 0;
    logic        rst = 0;
    logic        iv[3], ir[3], ov[3], ordy[3], fl[3];
    logic [63:0] id[3], od[3];
    logic [1:0]  cnt[3];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        int n = 0;
        logic [63:0] q[$];

        pipe_elastic_stage #(.WIDTH(64), .DEPTH(g == 1 ? 3 : 2), .BYPASS(g == 2)) dut (
            .clk       (clk),
            .reset     (rst),
            .flush     (fl[g]),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (od[g]),
            .count     (cnt[g])
        );

        // accepted inputs are queued, produced outputs must match the queue head
        always @(negedge clk) begin
            if (!rst || fl[g]) q.delete();
            else begin
                if (iv[g] && ir[g]) q.push_back(id[g]);
                if (ov[g] && ordy[g]) begin
                    if (q.size() == 0) chk($sformatf("sb%0d_extra", g), 64'(q.size()), 64'd1);
                    else begin
                        chk($sformatf("sb%0d_data", g), od[g], q.pop_front());
                        n++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = 0; ordy[k] = 0; fl[k] = 0; id[k] = '0;
        end
        repeat (2) step();
        rst = 1;
        repeat (3) step();
        chk("rst_count", 64'(cnt[0]), 0);
        chk("rst_out_valid", 64'(ov[0]), 0);
        chk("rst_out_data", od[0], 0);
        chk("rst_in_ready", 64'(ir[0]), 1);
        chk("rst_byp_out_valid", 64'(ov[2]), 0);

        iv[0] = 1; id[0] = 64'hA;
        step();
        chk("fill1_count", 64'(cnt[0]), 1);
        chk("fill1_in_ready", 64'(ir[0]), 1);
        chk("fill1_head", od[0], 64'hA);
        id[0] = 64'hB;
        step();
        chk("fill2_count", 64'(cnt[0]), 2);
        chk("fill2_in_ready", 64'(ir[0]), 0);
        id[0] = 64'hC;
        step();
        chk("full_count", 64'(cnt[0]), 2);
        chk("full_head_stable", od[0], 64'hA);
        iv[0] = 0; ordy[0] = 1;
        step();
        chk("drain_head", od[0], 64'hB);
        chk("drain_in_ready", 64'(ir[0]), 1);
        step();
        chk("drain_count", 64'(cnt[0]), 0);
        chk("fill_pops", 64'(u[0].n), 2);

        iv[0] = 1;
        for (int i = 1; i <= 10; i++) begin
            id[0] = 64'(i);
            step();
            chk("stream_count", 64'(cnt[0]), 1);
        end
        iv[0] = 0;
        step();
        chk("stream_end_count", 64'(cnt[0]), 0);
        chk("stream_pops", 64'(u[0].n), 12);
        ordy[0] = 0;

        iv[1] = 1; id[1] = 64'h11;
        step();
        id[1] = 64'h12;
        step();
        ordy[1] = 1;
        for (int i = 3; i <= 5; i++) begin
            id[1] = 64'h10 + 64'(i);
            step();
            chk("wrap_count", 64'(cnt[1]), 2);
        end
        iv[1] = 0;
        repeat (2) step();
        chk("wrap_pops", 64'(u[1].n), 5);
        chk("wrap_empty", 64'(cnt[1]), 0);

        ordy[1] = 0; iv[1] = 1; id[1] = 64'h21;
        step();
        id[1] = 64'h22;
        step();
        id[1] = 64'h99; fl[1] = 1;
        #1;
        chk("flush_offer_ready", 64'(ir[1]), 1);
        step();
        fl[1] = 0; iv[1] = 0;
        chk("flush_count", 64'(cnt[1]), 0);
        chk("flush_out_valid", 64'(ov[1]), 0);
        ordy[1] = 1;
        repeat (2) step();
        chk("flush_stays_empty", 64'(ov[1]), 0);
        iv[1] = 1; id[1] = 64'h33;
        step();
        iv[1] = 0;
        step();
        chk("post_flush_pops", 64'(u[1].n), 6);

        iv[0] = 1; id[0] = 64'h41;
        step();
        id[0] = 64'h42;
        step();
        iv[0] = 0;
        chk("pre_reset_count", 64'(cnt[0]), 2);
        rst = 0;
        step();
        rst = 1;
        chk("mid_rst_count", 64'(cnt[0]), 0);
        chk("mid_rst_out_valid", 64'(ov[0]), 0);
        chk("mid_rst_out_data", od[0], 0);
        chk("mid_rst_in_ready", 64'(ir[0]), 1);

        iv[2] = 1; ordy[2] = 1; id[2] = 64'h5A;
        #1;
        chk("byp_out_valid", 64'(ov[2]), 1);
        chk("byp_out_data", od[2], 64'h5A);
        step();
        chk("byp_count", 64'(cnt[2]), 0);
        ordy[2] = 0;
        step();
        iv[2] = 0; id[2] = 64'h0;
        #1;
        chk("byp_store_count", 64'(cnt[2]), 1);
        chk("byp_store_data", od[2], 64'h5A);
        step();
        chk("byp_hold_data", od[2], 64'h5A);
        ordy[2] = 1;
        step();
        chk("byp_drain_count", 64'(cnt[2]), 0);
        chk("byp_pops", 64'(u[2].n), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
